// File: rtl/gate_sweep_pkg.sv
// Shared state type, Gray vector order and reference truth tables
// for the gate sweep sequencer.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } sweep_state_t;

  // Sweep order {in_1,in_2}: one input toggles per step so the gate sees no double transitions.
  localparam logic [1:0] GRAY_VEC [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags expiry when it reaches zero; used to
// hold each sweep vector for a fixed number of cycles.
module settle_timer #(
  parameter int              WIDTH      = 3,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  // Stops at zero instead of wrapping; the sequencer reloads it per vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through all four input vectors in Gray order,
// captures its output per vector and compares against an expected table.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECTED      = TT_AND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in_1,
  output logic       in_2,
  input  logic       out_1,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] mismatch_mask,
  output logic       pass
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  sweep_state_t state, state_next;
  logic [1:0]   vec_idx;
  logic         timer_load, timer_en, timer_expire;
  logic         accept_start, do_abort, do_capture;
  logic         last_vec;

  assign last_vec = (vec_idx == 2'd3);

  settle_timer #(
    .WIDTH      (CW),
    .LOAD_VALUE (CW'(SETTLE_CYCLES - 1))
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Abort wins over both the settle expiry and the SAMPLE capture.
  always_comb begin
    state_next   = state;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    accept_start = 1'b0;
    do_abort     = 1'b0;
    do_capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          timer_load   = 1'b1;
          state_next   = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          do_abort   = 1'b1;
          state_next = IDLE;
        end else if (timer_expire) begin
          state_next = SAMPLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          do_abort   = 1'b1;
          state_next = IDLE;
        end else begin
          do_capture = 1'b1;
          if (last_vec) begin
            state_next = DONE;
          end else begin
            timer_load = 1'b1;
            state_next = APPLY;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gate drives are registered so the device under test only sees edge-aligned changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec_idx <= 2'd0;
      in_1    <= 1'b0;
      in_2    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept_start) begin
        vec_idx      <= 2'd0;
        {in_1, in_2} <= GRAY_VEC[0];
      end else if (do_abort) begin
        {in_1, in_2} <= 2'b00;
      end else if (do_capture) begin
        if (last_vec) begin
          {in_1, in_2} <= 2'b00;
        end else begin
          vec_idx      <= vec_idx + 2'd1;
          {in_1, in_2} <= GRAY_VEC[vec_idx + 2'd1];
        end
      end
    end
  end

  // An aborted sweep keeps its partial table for debug but never reports a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_table   <= 4'b0000;
      mismatch_mask <= 4'b0000;
      pass          <= 1'b0;
    end else if (accept_start) begin
      truth_table   <= 4'b0000;
      mismatch_mask <= 4'b0000;
      pass          <= 1'b0;
    end else if (do_abort) begin
      pass <= 1'b0;
    end else begin
      if (do_capture) begin
        truth_table[{in_1, in_2}] <= out_1;
      end
      if (state == DONE) begin
        mismatch_mask <= truth_table ^ EXPECTED;
        pass          <= (truth_table == EXPECTED);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
